// File: rtl/synchronizer_2ff_pkg.sv
// Shared types and helpers for the two-flop level synchronizer.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   edge_t      - rise/fall pulse pair for one synchronized bit
//   detect_edge - edge decode from the current and previous synchronized level
package synchronizer_2ff_pkg;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // Edge decode uses only registered inputs, so its outputs cannot glitch
  // on input activity.
  function automatic edge_t detect_edge(input logic cur, input logic prev);
    edge_t e;
    e.rise = cur & ~prev;
    e.fall = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/synchronizer_2ff_sync_ff_cell.sv
// Single-bit two-flop synchronizer with a history flop for edge detection.
// Latency: d -> q1 in 1 edge, d -> q2 in 2 edges; edge pulses are aligned with q2 changes.
// Backpressure: none (free-running level path, no enable).
//
// Ports:
//   clk      - sampling clock
//   reset    - asynchronous active-low clear to RESET_VAL
//   d        - asynchronous input level
//   q1       - first stage (may be metastable, diagnostic only)
//   q2       - synchronized level
//   q2_rise  - one-cycle pulse on q2 0->1
//   q2_fall  - one-cycle pulse on q2 1->0
module sync_ff_cell
  import synchronizer_2ff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q1,
  output logic q2,
  output logic q2_rise,
  output logic q2_fall
);

  // The two metastability-settling stages are tagged so placement keeps them
  // adjacent and no tool retimes or absorbs them into a shift-register primitive.
  (* ASYNC_REG = "TRUE" *) logic q1_r;
  (* ASYNC_REG = "TRUE" *) logic q2_r;
  logic  q2_d;
  edge_t edges;

  // All three flops clear together, so the edge decode sees q2_r == q2_d
  // during and right after reset: no spurious pulse from discarded data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1_r <= RESET_VAL;
      q2_r <= RESET_VAL;
      q2_d <= RESET_VAL;
    end else begin
      q1_r <= d;
      q2_r <= q1_r;
      q2_d <= q2_r;
    end
  end

  assign edges   = detect_edge(q2_r, q2_d);
  assign q1      = q1_r;
  assign q2      = q2_r;
  assign q2_rise = edges.rise;
  assign q2_fall = edges.fall;

endmodule

// File: rtl/synchronizer_2ff.sv
// WIDTH independent two-flop synchronizers with per-bit rise/fall pulses.
// Latency: D1 -> Q1 in 1 edge, D1 -> Q2 in 2 edges; pulses coincide with Q2 changes.
// Backpressure: none; input pulses shorter than one clk period may be lost.
//
// Ports:
//   clk      - sole clock, rising edge
//   reset    - asynchronous active-low; must be released synchronously to clk
//   D1       - asynchronous input levels [WIDTH]
//   Q1       - first-stage flops, diagnostic only [WIDTH]
//   Q2       - synchronized levels [WIDTH]
//   Q2_rise  - one-cycle pulse per bit on Q2 0->1 [WIDTH]
//   Q2_fall  - one-cycle pulse per bit on Q2 1->0 [WIDTH]
//
// Bits are not coherent with each other; only carry unrelated levels or
// Gray-coded values through a WIDTH > 1 instance.
module synchronizer_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D1,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q2_rise,
  output logic [WIDTH-1:0] Q2_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sync_ff_cell #(
      .RESET_VAL(RESET_VAL[i])
    ) u_cell (
      .clk     (clk),
      .reset   (reset),
      .d       (D1[i]),
      .q1      (Q1[i]),
      .q2      (Q2[i]),
      .q2_rise (Q2_rise[i]),
      .q2_fall (Q2_fall[i])
    );
  end

endmodule

// File: tb/tb_synchronizer_2ff.sv
// Directed self-checking bench for synchronizer_2ff (WIDTH=1 and WIDTH=4 instances).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after a rising edge.
// Expected values are hand-computed constants per scenario.
module tb_synchronizer_2ff;

  logic       clk;
  logic       rst_a;
  logic       rst_b;
  logic       d_a;
  logic       q1_a, q2_a, rise_a, fall_a;
  logic [3:0] d_b;
  logic [3:0] q1_b, q2_b, rise_b, fall_b;

  int n_cmp;
  int n_bad;

  synchronizer_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_dut_a (
    .clk     (clk),
    .reset   (rst_a),
    .D1      (d_a),
    .Q1      (q1_a),
    .Q2      (q2_a),
    .Q2_rise (rise_a),
    .Q2_fall (fall_a)
  );

  synchronizer_2ff #(
    .WIDTH     (4),
    .RESET_VAL (4'b1010)
  ) u_dut_b (
    .clk     (clk),
    .reset   (rst_b),
    .D1      (d_b),
    .Q1      (q1_b),
    .Q2      (q2_b),
    .Q2_rise (rise_b),
    .Q2_fall (fall_b)
  );

  // Rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Clear lands at t=1 with no clock edge yet: proves the clear is asynchronous.
    rst_a = 1'b0;
    rst_b = 1'b0;
    #1;
    n_cmp++; if (q1_a !== 1'b0) begin n_bad++; $display("FAIL reset_async_q1: got %b want 0", q1_a); end
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL reset_async_q2: got %b want 0", q2_a); end
    n_cmp++; if (rise_a !== 1'b0) begin n_bad++; $display("FAIL reset_async_rise: got %b want 0", rise_a); end
    n_cmp++; if (fall_a !== 1'b0) begin n_bad++; $display("FAIL reset_async_fall: got %b want 0", fall_a); end
    n_cmp++; if (q2_b !== 4'b1010) begin n_bad++; $display("FAIL reset_async_q2_w4: got %b want 1010", q2_b); end
    // D1 toggling while reset is held must not move anything.
    for (int i = 0; i < 3; i++) begin
      d_a = ~d_a;
      tick();
      n_cmp++; if (q1_a !== 1'b0) begin n_bad++; $display("FAIL reset_hold_q1[%0d]: got %b want 0", i, q1_a); end
      n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL reset_hold_q2[%0d]: got %b want 0", i, q2_a); end
      n_cmp++; if ((rise_a | fall_a) !== 1'b0) begin n_bad++; $display("FAIL reset_hold_pulse[%0d]: got rise=%b fall=%b want 0/0", i, rise_a, fall_a); end
    end
    d_a   = 1'b0;
    rst_a = 1'b1;
    tick();
    tick();
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL reset_release_q2: got %b want 0", q2_a); end
  endtask

  task automatic test_rise();
    d_a = 1'b1;
    tick();
    n_cmp++; if (q1_a !== 1'b1) begin n_bad++; $display("FAIL rise_e1_q1: got %b want 1", q1_a); end
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL rise_e1_q2: got %b want 0", q2_a); end
    n_cmp++; if (rise_a !== 1'b0) begin n_bad++; $display("FAIL rise_e1_pulse: got %b want 0", rise_a); end
    tick();
    n_cmp++; if (q2_a !== 1'b1) begin n_bad++; $display("FAIL rise_e2_q2: got %b want 1", q2_a); end
    n_cmp++; if (rise_a !== 1'b1) begin n_bad++; $display("FAIL rise_e2_pulse: got %b want 1", rise_a); end
    n_cmp++; if (fall_a !== 1'b0) begin n_bad++; $display("FAIL rise_e2_fall: got %b want 0", fall_a); end
    tick();
    n_cmp++; if (q2_a !== 1'b1) begin n_bad++; $display("FAIL rise_e3_q2: got %b want 1", q2_a); end
    n_cmp++; if (rise_a !== 1'b0) begin n_bad++; $display("FAIL rise_e3_pulse_end: got %b want 0", rise_a); end
  endtask

  task automatic test_fall();
    d_a = 1'b0;
    tick();
    n_cmp++; if (q1_a !== 1'b0) begin n_bad++; $display("FAIL fall_e1_q1: got %b want 0", q1_a); end
    n_cmp++; if (q2_a !== 1'b1) begin n_bad++; $display("FAIL fall_e1_q2: got %b want 1", q2_a); end
    n_cmp++; if (fall_a !== 1'b0) begin n_bad++; $display("FAIL fall_e1_pulse: got %b want 0", fall_a); end
    tick();
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL fall_e2_q2: got %b want 0", q2_a); end
    n_cmp++; if (fall_a !== 1'b1) begin n_bad++; $display("FAIL fall_e2_pulse: got %b want 1", fall_a); end
    n_cmp++; if (rise_a !== 1'b0) begin n_bad++; $display("FAIL fall_e2_rise: got %b want 0", rise_a); end
    tick();
    n_cmp++; if (fall_a !== 1'b0) begin n_bad++; $display("FAIL fall_e3_pulse_end: got %b want 0", fall_a); end
  endtask

  task automatic test_midflight_reset();
    d_a = 1'b1;
    tick();
    n_cmp++; if (q1_a !== 1'b1) begin n_bad++; $display("FAIL mid_inflight_q1: got %b want 1", q1_a); end
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL mid_inflight_q2: got %b want 0", q2_a); end
    #2 rst_a = 1'b0;
    #1;
    n_cmp++; if (q1_a !== 1'b0) begin n_bad++; $display("FAIL mid_clear_q1: got %b want 0", q1_a); end
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL mid_clear_q2: got %b want 0", q2_a); end
    n_cmp++; if (rise_a !== 1'b0) begin n_bad++; $display("FAIL mid_clear_rise: got %b want 0", rise_a); end
    tick();
    n_cmp++; if (q1_a !== 1'b0) begin n_bad++; $display("FAIL mid_held_q1: got %b want 0", q1_a); end
    rst_a = 1'b1;
    tick();
    n_cmp++; if (q1_a !== 1'b1) begin n_bad++; $display("FAIL mid_restart_e1_q1: got %b want 1", q1_a); end
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL mid_restart_e1_q2: got %b want 0", q2_a); end
    tick();
    n_cmp++; if (q2_a !== 1'b1) begin n_bad++; $display("FAIL mid_restart_e2_q2: got %b want 1", q2_a); end
    n_cmp++; if (rise_a !== 1'b1) begin n_bad++; $display("FAIL mid_restart_e2_rise: got %b want 1", rise_a); end
    // Clearing a high Q2 must not look like a falling edge.
    #1 rst_a = 1'b0;
    #1;
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL mid_clear_high_q2: got %b want 0", q2_a); end
    n_cmp++; if (fall_a !== 1'b0) begin n_bad++; $display("FAIL mid_clear_high_fall: got %b want 0", fall_a); end
    tick();
    n_cmp++; if (fall_a !== 1'b0) begin n_bad++; $display("FAIL mid_clear_held_fall: got %b want 0", fall_a); end
    d_a   = 1'b0;
    rst_a = 1'b1;
    tick();
    tick();
    n_cmp++; if ((q2_a | fall_a | rise_a) !== 1'b0) begin n_bad++; $display("FAIL mid_settle: got q2=%b rise=%b fall=%b want 0/0/0", q2_a, rise_a, fall_a); end
  endtask

  task automatic test_short_pulse();
    // High for 3 ns strictly between edges: no edge ever samples it.
    d_a = 1'b1;
    #3 d_a = 1'b0;
    tick();
    n_cmp++; if (q1_a !== 1'b0) begin n_bad++; $display("FAIL short_q1: got %b want 0", q1_a); end
    tick();
    n_cmp++; if (q2_a !== 1'b0) begin n_bad++; $display("FAIL short_q2: got %b want 0", q2_a); end
    n_cmp++; if ((rise_a | fall_a) !== 1'b0) begin n_bad++; $display("FAIL short_pulse: got rise=%b fall=%b want 0/0", rise_a, fall_a); end
  endtask

  task automatic test_back_to_back();
    // Bit i is the D1 value driven before edge i, and the expected outputs after it.
    logic [6:0] d_seq;
    logic [6:0] exp_q2;
    logic [6:0] exp_rise;
    logic [6:0] exp_fall;
    d_seq    = 7'b0010101;
    exp_q2   = 7'b0101010;
    exp_rise = 7'b0101010;
    exp_fall = 7'b1010100;
    for (int i = 0; i < 7; i++) begin
      d_a = d_seq[i];
      tick();
      n_cmp++; if (q1_a !== d_seq[i]) begin n_bad++; $display("FAIL b2b_q1[%0d]: got %b want %b", i, q1_a, d_seq[i]); end
      n_cmp++; if (q2_a !== exp_q2[i]) begin n_bad++; $display("FAIL b2b_q2[%0d]: got %b want %b", i, q2_a, exp_q2[i]); end
      n_cmp++; if (rise_a !== exp_rise[i]) begin n_bad++; $display("FAIL b2b_rise[%0d]: got %b want %b", i, rise_a, exp_rise[i]); end
      n_cmp++; if (fall_a !== exp_fall[i]) begin n_bad++; $display("FAIL b2b_fall[%0d]: got %b want %b", i, fall_a, exp_fall[i]); end
    end
  endtask

  task automatic test_width4();
    // Reset held since t=1 while D1=0101 and edges have been running.
    n_cmp++; if (q1_b !== 4'b1010) begin n_bad++; $display("FAIL w4_reset_q1: got %b want 1010", q1_b); end
    n_cmp++; if (q2_b !== 4'b1010) begin n_bad++; $display("FAIL w4_reset_q2: got %b want 1010", q2_b); end
    n_cmp++; if ((rise_b | fall_b) !== 4'b0000) begin n_bad++; $display("FAIL w4_reset_pulse: got rise=%b fall=%b want 0000/0000", rise_b, fall_b); end
    rst_b = 1'b1;
    tick();
    n_cmp++; if (q1_b !== 4'b0101) begin n_bad++; $display("FAIL w4_e1_q1: got %b want 0101", q1_b); end
    n_cmp++; if (q2_b !== 4'b1010) begin n_bad++; $display("FAIL w4_e1_q2: got %b want 1010", q2_b); end
    n_cmp++; if ((rise_b | fall_b) !== 4'b0000) begin n_bad++; $display("FAIL w4_e1_pulse: got rise=%b fall=%b want 0000/0000", rise_b, fall_b); end
    tick();
    n_cmp++; if (q2_b !== 4'b0101) begin n_bad++; $display("FAIL w4_e2_q2: got %b want 0101", q2_b); end
    n_cmp++; if (rise_b !== 4'b0101) begin n_bad++; $display("FAIL w4_e2_rise: got %b want 0101", rise_b); end
    n_cmp++; if (fall_b !== 4'b1010) begin n_bad++; $display("FAIL w4_e2_fall: got %b want 1010", fall_b); end
    tick();
    n_cmp++; if (q2_b !== 4'b0101) begin n_bad++; $display("FAIL w4_e3_q2: got %b want 0101", q2_b); end
    n_cmp++; if ((rise_b | fall_b) !== 4'b0000) begin n_bad++; $display("FAIL w4_e3_pulse_end: got rise=%b fall=%b want 0000/0000", rise_b, fall_b); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    d_a   = 1'b0;
    d_b   = 4'b0101;
    #1;
    test_reset();
    test_rise();
    test_fall();
    test_midflight_reset();
    test_short_pulse();
    test_back_to_back();
    test_width4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
